// File: rtl/lvds_video_rx.sv
// Receive side of the 18-bit LVDS video link: deserialises three data lanes plus
// the clock lane at 7x rate, qualifies word alignment and unpacks RGB666 + syncs.
module lvds_video_rx #(
    parameter int unsigned LOCK_WORDS  = 4,
    parameter int unsigned LOSS_WORDS  = 2,
    parameter logic [6:0]  CLK_PATTERN = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch1_in,
    input  logic       ch2_in,
    input  logic       ch3_in,
    input  logic       clk_in,
    output logic [5:0] red,
    output logic [5:0] green,
    output logic [5:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       pix_valid,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam int unsigned WORD_W  = 7;
    localparam int unsigned PH_W    = 3;
    localparam int unsigned MATCH_W = $clog2(LOCK_WORDS + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_WORDS + 1);
    localparam int unsigned ERR_W   = 8;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_CONFIRM,
        ST_LOCKED
    } state_e;

    typedef struct packed {
        logic [5:0] red;
        logic [5:0] green;
        logic [5:0] blue;
        logic       hsync;
        logic       vsync;
        logic       de;
    } pixel_t;

    logic [WORD_W-1:0]  ch1_q, ch1_d;
    logic [WORD_W-1:0]  ch2_q, ch2_d;
    logic [WORD_W-1:0]  ch3_q, ch3_d;
    logic [WORD_W-1:0]  clk_sr_q, clk_sr_d;
    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    pixel_t             pix_q, pix_d;
    logic               pix_valid_q, pix_valid_d;
    logic               locked_q, locked_d;

    logic               clk_match_c;
    logic               word_edge_c;
    pixel_t             unpacked_c;

    // Lane shifters: first transmitted bit ends up in bit 6.
    always_comb begin
        ch1_d    = {ch1_q[WORD_W-2:0], ch1_in};
        ch2_d    = {ch2_q[WORD_W-2:0], ch2_in};
        ch3_d    = {ch3_q[WORD_W-2:0], ch3_in};
        clk_sr_d = {clk_sr_q[WORD_W-2:0], clk_in};
    end

    assign clk_match_c = (clk_sr_q == CLK_PATTERN);
    assign word_edge_c = (phase_q == '0);

    // Lane bit order is LSB-of-colour first, so each colour comes out bit-reversed.
    always_comb begin
        unpacked_c.red   = {ch1_q[1], ch1_q[2], ch1_q[3], ch1_q[4], ch1_q[5], ch1_q[6]};
        unpacked_c.green = {ch2_q[2], ch2_q[3], ch2_q[4], ch2_q[5], ch2_q[6], ch1_q[0]};
        unpacked_c.blue  = {ch3_q[3], ch3_q[4], ch3_q[5], ch3_q[6], ch2_q[0], ch2_q[1]};
        unpacked_c.hsync = ch3_q[2];
        unpacked_c.vsync = ch3_q[1];
        unpacked_c.de    = ch3_q[0];
    end

    // Alignment FSM, word counters and output latching.
    always_comb begin
        state_d     = state_q;
        phase_d     = (phase_q == PH_W'(WORD_W - 1)) ? '0 : phase_q + PH_W'(1);
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        pix_d       = pix_q;
        pix_valid_d = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (clk_match_c) begin
                    phase_d     = PH_W'(1);
                    match_cnt_d = MATCH_W'(1);
                    miss_cnt_d  = '0;
                    state_d     = (LOCK_WORDS <= 1) ? ST_LOCKED : ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (word_edge_c) begin
                    if (clk_match_c) begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (match_cnt_q == MATCH_W'(LOCK_WORDS - 1)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                        state_d     = ST_SEARCH;
                    end
                end
            end
            ST_LOCKED: begin
                if (word_edge_c) begin
                    if (clk_match_c) begin
                        pix_d       = unpacked_c;
                        pix_valid_d = 1'b1;
                        miss_cnt_d  = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_cnt_q == MISS_W'(LOSS_WORDS - 1)) begin
                            state_d     = ST_SEARCH;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch1_q       <= '0;
            ch2_q       <= '0;
            ch3_q       <= '0;
            clk_sr_q    <= '0;
            state_q     <= ST_SEARCH;
            phase_q     <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
            ch3_q       <= ch3_d;
            clk_sr_q    <= clk_sr_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            locked_q    <= locked_d;
        end
    end

    assign red       = pix_q.red;
    assign green     = pix_q.green;
    assign blue      = pix_q.blue;
    assign hsync     = pix_q.hsync;
    assign vsync     = pix_q.vsync;
    assign de        = pix_q.de;
    assign pix_valid = pix_valid_q;
    assign locked    = locked_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lvds_video_rx.sv
// Bench for lvds_video_rx: builds a lane bit stream up front, derives the expected
// per-cycle outputs from a time-based word model, then replays and compares.
module tb_lvds_video_rx;

    localparam logic [6:0] PAT    = 7'b1100011;
    localparam int         LOCK_N = 4;
    localparam int         LOSS_N = 2;
    localparam int         MAXN   = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       ch1_in, ch2_in, ch3_in, clk_in;
    logic [5:0] red, green, blue;
    logic       hsync, vsync, de, pix_valid, locked;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fix_end;

    // Each entry: {clock lane, ch1, ch2, ch3}
    logic [3:0]  stream[$];
    logic        exp_v[0:MAXN];
    logic        exp_l[0:MAXN];
    logic [7:0]  exp_e[0:MAXN];
    logic [20:0] exp_p[0:MAXN];

    localparam logic [20:0] PX_FIX = {6'h3F, 6'h00, 6'h2A, 1'b1, 1'b0, 1'b1};

    lvds_video_rx dut (
        .clk(clk), .rst(rst),
        .ch1_in(ch1_in), .ch2_in(ch2_in), .ch3_in(ch3_in), .clk_in(clk_in),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de),
        .pix_valid(pix_valid), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // Serialise one word: pixel layout {R7..R2, G7..G2, B7..B2, HS, VS, DE}.
    task automatic push_word(input logic [6:0] cw, input logic [20:0] px);
        logic [5:0] r, g, b;
        logic [6:0] w1, w2, w3;
        {r, g, b} = px[20:3];
        w1 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
        w2 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
        w3 = {b[2], b[3], b[4], b[5], px[2], px[1], px[0]};
        for (int i = 6; i >= 0; i--) stream.push_back({cw[i], w1[i], w2[i], w3[i]});
    endtask

    function automatic logic [6:0] bad_cw();
        logic [6:0] c;
        c = 7'($urandom);
        if (c == PAT) c = c ^ 7'h01;
        return c;
    endfunction

    task automatic push_good(input int n);
        for (int i = 0; i < n; i++) push_word(PAT, 21'($urandom));
    endtask

    function automatic logic [6:0] win(input int lane, input int t);
        logic [6:0] w;
        for (int k = 0; k < 7; k++) begin
            int idx;
            idx = t - 6 + k;
            w[6 - k] = (idx >= 0) ? stream[idx][lane] : 1'b0;
        end
        return w;
    endfunction

    // Word-level reference: after a pattern hit, words are checked every 7 bits.
    task automatic build_expect(input int n);
        int mode = 0;
        int good = 0;
        int miss = 0;
        int nxt  = 0;
        int err  = 0;
        logic [20:0] px = '0;
        logic [6:0] cw, w1, w2, w3;
        logic v;
        exp_v[0] = 1'b0; exp_l[0] = 1'b0; exp_e[0] = '0; exp_p[0] = '0;
        for (int t = 0; t < n; t++) begin
            cw = win(3, t);
            v  = 1'b0;
            if (mode == 0) begin
                if (cw == PAT) begin
                    good = 1;
                    nxt  = t + 7;
                    mode = (good >= LOCK_N) ? 2 : 1;
                end
            end else if (t == nxt) begin
                nxt += 7;
                if (mode == 1) begin
                    if (cw == PAT) begin
                        good++;
                        if (good >= LOCK_N) mode = 2;
                    end else begin
                        mode = 0;
                        good = 0;
                    end
                end else if (cw == PAT) begin
                    w1 = win(2, t); w2 = win(1, t); w3 = win(0, t);
                    px = {w1[1], w1[2], w1[3], w1[4], w1[5], w1[6],
                          w2[2], w2[3], w2[4], w2[5], w2[6], w1[0],
                          w3[3], w3[4], w3[5], w3[6], w2[0], w2[1],
                          w3[2], w3[1], w3[0]};
                    v    = 1'b1;
                    miss = 0;
                end else begin
                    miss++;
                    if (err < 255) err++;
                    if (miss >= LOSS_N) begin
                        mode = 0; good = 0; miss = 0;
                    end
                end
            end
            exp_v[t+1] = v;
            exp_l[t+1] = (mode == 2);
            exp_e[t+1] = 8'(err);
            exp_p[t+1] = px;
        end
    endtask

    initial begin
        rst = 1'b0;
        {clk_in, ch1_in, ch2_in, ch3_in} = '0;

        // Start 3 bits into a word, then the fixed test-plan pixel.
        stream.push_back({1'b0, 3'($urandom)});
        stream.push_back({1'b1, 3'($urandom)});
        stream.push_back({1'b1, 3'($urandom)});
        for (int i = 0; i < 10; i++) push_word(PAT, PX_FIX);
        fix_end = stream.size();
        push_good(10);
        // Single glitched clock word while locked.
        push_word(bad_cw(), 21'($urandom));
        push_good(10);
        // Bit slip on every lane.
        stream.push_back(4'($urandom));
        push_good(12);
        // Random mix of glitches and slips.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) stream.push_back(4'($urandom));
            if ($urandom_range(0, 4) == 0) push_word(bad_cw(), 21'($urandom));
            else push_word(PAT, 21'($urandom));
        end
        push_good(8);
        // Error counter saturation with lock held.
        for (int i = 0; i < 300; i++) begin
            push_word(bad_cw(), 21'($urandom));
            push_word(PAT, 21'($urandom));
        end
        push_good(10);

        build_expect(stream.size());

        // Reset held with toggling lanes.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            {clk_in, ch1_in, ch2_in, ch3_in} = 4'($urandom);
            @(posedge clk);
            #1;
            check_eq("rst_valid", 32'(pix_valid), 32'd0);
            check_eq("rst_locked", 32'(locked), 32'd0);
            check_eq("rst_err", 32'(err_cnt), 32'd0);
            check_eq("rst_pixel", 32'({red, green, blue, hsync, vsync, de}), 32'd0);
        end

        for (int t = 0; t < stream.size(); t++) begin
            @(negedge clk);
            rst = 1'b1;
            {clk_in, ch1_in, ch2_in, ch3_in} = stream[t];
            @(posedge clk);
            #1;
            cyc = t;
            check_eq("pix_valid", 32'(pix_valid), 32'(exp_v[t]));
            check_eq("locked", 32'(locked), 32'(exp_l[t]));
            check_eq("err_cnt", 32'(err_cnt), 32'(exp_e[t]));
            check_eq("pixel", 32'({red, green, blue, hsync, vsync, de}), 32'(exp_p[t]));
            if (exp_v[t] && t <= fix_end)
                check_eq("fix_pixel", 32'({red, green, blue, hsync, vsync, de}), 32'(PX_FIX));
        end

        check_eq("err_saturated", 32'(err_cnt), 32'd255);
        check_eq("locked_at_end", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
